// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between a fetch port and a data port.
// Data wins by default; after MAX_D_BURST data grants with a fetch waiting, the fetch wins.
module mem_arbiter #(
    parameter int MAX_D_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall
);
    localparam int SW = $clog2(MAX_D_BURST + 1);
    localparam logic [SW-1:0] SMAX = SW'(MAX_D_BURST);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state, state_nx;
    logic [SW-1:0] streak, streak_nx;
    logic          win_d, we_r, grant, pick_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_nx;
            streak <= streak_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        streak_nx = streak;
        grant     = (state == IDLE) & (if_req | d_req);
        pick_d    = d_req & ~(if_req & (streak == SMAX));
        state_nx  = (state == IDLE) ? (grant ? BUSY : IDLE) :
                    (state == BUSY) ? (mem_ready ? RESP : BUSY) : IDLE;
        // a waiting fetch lengthens the streak; anything else in IDLE resets it
        if (state == IDLE)
            streak_nx = (if_req & pick_d) ? ((streak == SMAX) ? streak : streak + 1'b1) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_d     <= 1'b0;
            we_r      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if (grant) begin
                win_d     <= pick_d;
                we_r      <= pick_d & d_we;
                mem_addr  <= pick_d ? d_addr : if_addr;
                mem_wdata <= pick_d ? d_wdata : '0;
            end
            if (state == BUSY && mem_ready && !we_r) begin
                if (win_d)
                    d_rdata <= mem_rdata;
                else
                    if_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req = (state == BUSY);
    assign mem_we  = mem_req & we_r;
    assign if_ack  = (state == RESP) & ~win_d;
    assign d_ack   = (state == RESP) & win_d;
    assign stall   = (if_req & ~if_ack) | (d_req & ~d_ack);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests with a transaction-level reference model checked every cycle.
module tb_mem_arbiter;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic        if_ack, d_ack, mem_req, mem_we, stall;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    int total = 0;
    int bad = 0;

    mem_arbiter #(.MAX_D_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic void chk1(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endfunction

    // reference: one in-flight transaction record plus the owed ack
    bit          m_live = 0, m_done = 0, m_data = 0, m_we = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_ird = '0, m_drd = '0;
    int          m_streak = 0;

    always @(posedge clk or negedge reset) begin
        bit pd;
        if (!reset) begin
            m_live <= 0; m_done <= 0; m_data <= 0; m_we <= 0;
            m_addr <= '0; m_wdata <= '0; m_ird <= '0; m_drd <= '0; m_streak <= 0;
        end else if (m_done) begin
            m_done <= 0;
        end else if (m_live) begin
            if (mem_ready) begin
                m_live <= 0;
                m_done <= 1;
                if (!m_data) m_ird <= mem_rdata;
                else if (!m_we) m_drd <= mem_rdata;
            end
        end else if (if_req || d_req) begin
            pd = d_req && !(if_req && m_streak == MAXB);
            m_live   <= 1;
            m_data   <= pd;
            m_we     <= pd && d_we;
            m_addr   <= pd ? d_addr : if_addr;
            m_wdata  <= pd ? d_wdata : 32'h0;
            m_streak <= (pd && if_req) ? ((m_streak < MAXB) ? m_streak + 1 : MAXB) : 0;
        end else begin
            m_streak <= 0;
        end
    end

    always @(negedge clk) if (reset) begin
        chk1("mem_req", mem_req, m_live);
        chk1("mem_we", mem_we, m_live & m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk1("if_ack", if_ack, m_done & !m_data);
        chk1("d_ack", d_ack, m_done & m_data);
        chk("if_rdata", if_rdata, m_ird);
        chk("d_rdata", d_rdata, m_drd);
        chk1("stall", stall, (if_req & !(m_done & !m_data)) | (d_req & !(m_done & m_data)));
        chk1("ack_excl", if_ack & d_ack, 1'b0);
        chk("streak", 32'(dut.streak), m_streak);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int waits, input int drop_at,
                       output int ack_c, output int busy_n, output logic st_ack);
        ack_c = -1; busy_n = 0; st_ack = 1'bx;
        if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; end
        else begin if_req = 1; if_addr = addr; end
        mem_rdata = rd;
        for (int c = 0; c < 20 && ack_c < 0; c++) begin
            mem_ready = (c > waits);
            if (c == drop_at) begin if_req = 0; d_req = 0; end
            @(negedge clk);
            if (mem_req) busy_n++;
            if (is_d ? d_ack : if_ack) begin ack_c = c; st_ack = stall; end
            step();
        end
        if_req = 0; d_req = 0;
    endtask

    task automatic both(input bit keep_d, output int d_n, output int d_first, output int if_c);
        bit da;
        d_n = 0; d_first = -1; if_c = -1;
        if_req = 1; if_addr = 32'h400; d_req = 1; d_we = 0; d_addr = 32'h3000; d_wdata = '0;
        mem_ready = 1; mem_rdata = 32'h0BADF00D;
        for (int c = 0; c < 40 && if_c < 0; c++) begin
            @(negedge clk);
            da = d_ack;
            if (da) begin d_n++; if (d_first < 0) d_first = c; end
            if (if_ack) begin
                if_c = c;
                chk("streak_after_fetch", 32'(dut.streak), 32'h0);
            end
            step();
            if (da && !keep_d) d_req = 0;
        end
        if_req = 0; d_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, n, dn, df, ic;
        logic s;
        reset = 1;
        #3 reset = 0;
        #9;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_if_ack", if_ack, 1'b0);
        chk1("rst_d_ack", d_ack, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        step();
        reset = 1;
        step();
        step();

        txn(0, 0, 32'h100, 32'h0, 32'h00500093, 0, -1, a, b, s);
        chk("fetch_ack_cycle", a, 2);
        chk("fetch_busy_cycles", b, 1);
        chk("fetch_rdata", if_rdata, 32'h00500093);
        chk1("fetch_stall_at_ack", s, 1'b0);

        txn(1, 1, 32'h2000, 32'hDEADBEEF, 32'h12345678, 3, -1, a, b, s);
        chk("store_ack_cycle", a, 5);
        chk("store_busy_cycles", b, 4);
        chk("store_d_rdata", d_rdata, 32'h0);
        chk1("store_stall_at_ack", s, 1'b0);

        txn(1, 0, 32'h40, 32'h0, 32'hCAFE0001, 2, 2, a, b, s);
        chk("dropped_ack_cycle", a, 4);
        chk("dropped_d_rdata", d_rdata, 32'hCAFE0001);

        both(0, dn, df, ic);
        chk("simul_d_acks", dn, 1);
        chk("simul_d_cycle", df, 2);
        chk("simul_if_cycle", ic, 5);
        chk("simul_if_rdata", if_rdata, 32'h0BADF00D);

        both(1, dn, df, ic);
        chk("starve_d_acks", dn, 4);
        chk("starve_if_cycle", ic, 14);

        d_req = 1; d_we = 0; d_addr = 32'h5000; mem_ready = 0; mem_rdata = 32'h77;
        step();
        chk1("rbusy_mem_req", mem_req, 1'b1);
        #2 reset = 0;
        #1;
        chk1("rbusy_mem_req_cleared", mem_req, 1'b0);
        chk("rbusy_mem_addr_cleared", mem_addr, 32'h0);
        chk("rbusy_d_rdata_cleared", d_rdata, 32'h0);
        d_req = 0; mem_ready = 1;
        step();
        reset = 1;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (d_ack) n++;
        end
        chk("rbusy_no_ack", n, 0);
        step();
        txn(1, 0, 32'h6000, 32'h0, 32'h600DCAFE, 1, -1, a, b, s);
        chk("after_reset_ack_cycle", a, 3);
        chk("after_reset_d_rdata", d_rdata, 32'h600DCAFE);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_D_BURST, default 4: the maximum number of consecutive data grants while a fetch is waiting.
REQ-002 clk  in  1  the single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low; all state clears immediately when reset=0.
REQ-004 if_req  in  1  instruction-fetch request; held with if_addr until if_ack.
REQ-005 if_addr  in  32  fetch address.
REQ-006 if_ack  out  1  one-cycle pulse; fetch complete, if_rdata valid.
REQ-007 if_rdata  out  32  registered fetch data.
REQ-008 d_req  in  1  load/store request; held with d_we/d_addr/d_wdata until d_ack.
REQ-009 d_we  in  1  1=store, 0=load.
REQ-010 d_addr  in  32  data address.
REQ-011 d_wdata  in  32  store data.
REQ-012 d_ack  out  1  one-cycle pulse; data access complete.
REQ-013 d_rdata  out  32  registered load data.
REQ-014 mem_req  out  1  request to the shared single-port memory.
REQ-015 mem_we  out  1  memory write enable.
REQ-016 mem_addr  out  32  memory address.
REQ-017 mem_wdata  out  32  memory write data.
REQ-018 mem_rdata  in  32  memory read data; valid when mem_ready=1.
REQ-019 mem_ready  in  1  memory completes the current access in this cycle.
REQ-020 stall  out  1  combinational; 1 when (if_req & ~if_ack) | (d_req & ~d_ack).

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-022 In IDLE, with any request pending, the FSM SHALL go to BUSY at the next edge, latch the winner ID and payload, and latch mem_we=d_we for data or mem_we=0 for fetch.
REQ-023 Arbitration SHALL be data over fetch, except for the fairness rule in REQ-024.
REQ-024 Fairness: when both requests are pending in IDLE and streak==MAX_D_BURST, fetch SHALL win.
- The streak counter SHALL increment on each data grant made while if_req=1.
- It SHALL clear on every fetch grant and whenever if_req=0 in IDLE.
- It SHALL saturate at MAX_D_BURST.
REQ-025 In BUSY, mem_req SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL be driven from the latched registers, stable until mem_ready.
REQ-026 In BUSY with mem_ready=1, the FSM SHALL go to RESP at the edge.
- A fetch or load SHALL capture mem_rdata into the winner's rdata register.
- A store SHALL leave d_rdata unchanged.
REQ-027 In RESP, the winner's ack SHALL be 1 for exactly one cycle, mem_req SHALL be 0, and the FSM SHALL return to IDLE unconditionally.
REQ-028 The requester deasserts req on the ack edge; IDLE SHALL therefore never regrant a completed request.
REQ-029 Latency: req rising at cycle 0 with mem_ready=1 at cycle 1 SHALL give ack at cycle 2. Each extra mem_ready=0 cycle adds one cycle.
REQ-030 mem_req SHALL be 0 in IDLE and RESP. mem_wdata SHALL be 0 for fetch transactions.
REQ-031 A request dropped during BUSY is a protocol violation. The transaction SHALL still complete and ack SHALL still pulse.
REQ-032 Requests arriving while BUSY or RESP SHALL wait. They SHALL not be lost and SHALL not be granted mid-transaction.
REQ-033 if_ack and d_ack SHALL never be 1 in the same cycle.

Reset
REQ-034 reset=0 SHALL force, without a clock edge:
- state to IDLE and streak to 0;
- mem_req, mem_we, if_ack, d_ack to 0;
- mem_addr, mem_wdata, if_rdata, d_rdata to 0.
REQ-035 Reset asserted in BUSY SHALL abandon the transaction; no ack SHALL follow.
REQ-036 After reset release, the first grant SHALL occur no earlier than the first rising edge with reset=1.

Verification
REQ-037 Fetch only: if_req=1, if_addr=0x100, mem_ready=1 at cycle 1, mem_rdata=0x00500093 -> if_ack at cycle 2, if_rdata=0x00500093, mem_we=0 throughout.
REQ-038 Store with wait states: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, mem_ready low for 3 cycles -> mem_addr/mem_wdata stable 4 cycles, d_ack at cycle 5, d_rdata unchanged.
REQ-039 Simultaneous if_req and d_req in IDLE, streak=0 -> data granted first, fetch second; if_ack follows d_ack by 3 cycles with mem_ready tied 1.
REQ-040 Starvation: d_req continuously re-raised and if_req held, MAX_D_BURST=4 -> exactly 4 d_acks, then if_ack, then streak=0.
REQ-041 Reset mid-BUSY: reset=0 during a load -> mem_req=0 immediately, no d_ack after release, next request served normally.
REQ-042 stall checks:
- stall=1 from req assertion through the cycle before ack, and 0 in the ack cycle when no other request is pending.
- Throughout REQ-037..REQ-041, if_ack and d_ack are never 1 in the same cycle.
